alu_uart_sequencer: RTL and testbench
=====================================

Name: alu_uart_sequencer

Overview:
- Frame sequencer between a byte-stream UART (RX/TX byte handshakes) and the registered 6-bit-opcode ALU.
- Collects a 3-byte command frame (A, B, Op), drives the ALU operands and opcode, and waits for the registered result.
- Returns a 2-byte response: result byte, then status byte.
- Top-level glue for the ALU-over-UART test design.

Parameters:
- N, 8, ALU operand/result width (1..8); A/B/result carried in one byte.
- NSel, 6, ALU opcode width.
- TIMEOUT, 1_000_000, max clock cycles between bytes of one frame before abort.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  one-cycle pulse: i_rx_data valid.
- i_rx_data  in  8  received byte.
- i_tx_done  in  1  one-cycle pulse: TX finished current byte.
- i_alu_result  in  N  ALU result.
- i_alu_overflow  in  1  ALU overflow flag.
- o_alu_A  out  N  operand A to ALU.
- o_alu_B  out  N  operand B to ALU.
- o_alu_Op  out  NSel  opcode to ALU.
- o_tx_start  out  1  one-cycle pulse: start sending o_tx_data.
- o_tx_data  out  8  byte to transmit.
- o_busy  out  1  high in any state except IDLE.
- o_timeout  out  1  one-cycle pulse on frame abort.

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0. Reset mid-frame or mid-send aborts immediately with no further tx_start.
- FSM states: IDLE, GET_B, GET_OP, EXEC, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT.
- IDLE: on i_rx_done, o_alu_A <= i_rx_data[N-1:0]; go to GET_B.
- GET_B: on i_rx_done, o_alu_B <= i_rx_data[N-1:0]; go to GET_OP.
- GET_OP: on i_rx_done, o_alu_Op <= i_rx_data[NSel-1:0]; go to EXEC. Upper byte bits are ignored. Opcode is not validated; an unknown opcode yields ALU result 0.
- EXEC: lasts exactly 2 cycles (the ALU result and flag are registered). Operands and opcode are held constant.
  - On the last EXEC cycle, latch i_alu_result, zero-extended to 8 bits, into o_tx_data.
  - Latch i_alu_overflow into an internal status register.
- SEND_RES: single cycle; o_tx_start=1; go to WAIT_RES.
- WAIT_RES: hold o_tx_data until i_tx_done, then go to SEND_STAT.
- SEND_STAT: o_tx_data={7'b0,ovf}; o_tx_start=1 for one cycle; go to WAIT_STAT.
- WAIT_STAT: on i_tx_done, go to IDLE.
- Latency: frame-end rx_done (sampled in GET_OP) to first o_tx_start = 3 cycles.
- o_tx_start is never high in two consecutive cycles. No second start is issued before i_tx_done.
- i_rx_done in EXEC/SEND_*/WAIT_* is dropped; ALU outputs are unchanged.
- i_tx_done outside WAIT_* is ignored.
- Timeout: the counter resets on every accepted rx byte and counts only in GET_B/GET_OP.
  - At count == TIMEOUT-1: pulse o_timeout, return to IDLE.
  - o_alu_A/B/Op keep their last values.
- rx_done in the same cycle the timeout expires: the timeout wins; the byte is dropped.
- WAIT_* states have no timeout; TX completion is guaranteed by the UART.
- o_alu_* retain their values after the response, until overwritten by the next frame.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Sequencer state encoding.
  - FRAME_LEN=3, RESP_LEN=2.
- Sub-module frame_timer: clear/enable inputs, expire output, width $clog2(TIMEOUT).
- FSM and datapath registers stay in alu_uart_sequencer.
- The testbench instantiates this block with the real ALU and a UART byte model.

Test Plan:
- Bytes 0x05,0x03,0x20 (ADD) -> o_alu_A=5, B=3, Op=0x20. First tx_start 3 cycles after the third rx_done with o_tx_data=0x08. After tx_done, second tx_start with 0x00.
- Bytes 0x7F,0x01,0x20 -> response 0x80 then 0x01 (overflow). Then 0x0F,0x3C,0x24 (AND) -> 0x0C, 0x00.
- Bytes 0xAA,0x55,0x3F (unknown Op) -> response 0x00, 0x00; o_busy returns to 0 after the second tx_done.
- TIMEOUT=16: send 0x11 then nothing -> o_timeout pulses 16 cycles after rx_done, o_busy=0. Next frame 0x02,0x02,0x22 (SUB) -> 0x00, 0x00.
- Extra rx_done (0xFF) while in WAIT_RES -> ignored; o_alu_A unchanged; exactly 2 tx_start pulses per frame.
- Assert i_reset during GET_OP and again during WAIT_RES -> next cycle all outputs 0, state IDLE, no tx_start. A following full frame completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU-over-UART design. Holds the
//                ALU opcodes, the frame and response lengths, and the
//                sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // ALU opcodes (6-bit)
  localparam logic [5:0] c_OP_ADD = 6'b100000;
  localparam logic [5:0] c_OP_SUB = 6'b100010;
  localparam logic [5:0] c_OP_AND = 6'b100100;
  localparam logic [5:0] c_OP_OR  = 6'b100101;
  localparam logic [5:0] c_OP_XOR = 6'b100110;
  localparam logic [5:0] c_OP_SRA = 6'b000011;
  localparam logic [5:0] c_OP_SRL = 6'b000010;
  localparam logic [5:0] c_OP_NOR = 6'b100111;

  // Bytes per command frame (A, B, Op) and per response (result, status)
  localparam int c_FRAME_LEN = 3;
  localparam int c_RESP_LEN  = 2;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_B     = 3'd1,
    S_GET_OP    = 3'd2,
    S_EXEC      = 3'd3,
    S_SEND_RES  = 3'd4,
    S_WAIT_RES  = 3'd5,
    S_SEND_STAT = 3'd6,
    S_WAIT_STAT = 3'd7
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_uart_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_uart_sequencer_if
//  Description : UART byte handshakes and ALU operand/result bus seen by the
//                frame sequencer. The master modport is the sequencer side;
//                the slave modport is the UART/ALU side.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_uart_sequencer_if #(
  parameter int N    = 8,
  parameter int NSel = 6
);
  logic            i_rx_done;
  logic [7:0]      i_rx_data;
  logic            i_tx_done;
  logic [N-1:0]    i_alu_result;
  logic            i_alu_overflow;
  logic [N-1:0]    o_alu_A;
  logic [N-1:0]    o_alu_B;
  logic [NSel-1:0] o_alu_Op;
  logic            o_tx_start;
  logic [7:0]      o_tx_data;
  logic            o_busy;
  logic            o_timeout;

  modport master (
    input  i_rx_done, i_rx_data, i_tx_done, i_alu_result, i_alu_overflow,
    output o_alu_A, o_alu_B, o_alu_Op, o_tx_start, o_tx_data, o_busy, o_timeout
  );

  modport slave (
    output i_rx_done, i_rx_data, i_tx_done, i_alu_result, i_alu_overflow,
    input  o_alu_A, o_alu_B, o_alu_Op, o_tx_start, o_tx_data, o_busy, o_timeout
  );
endinterface
`default_nettype wire

// File: rtl/alu_uart_sequencer_frame_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : frame_timer
//  Description : Inter-byte watchdog. Counts enabled cycles since the last
//                clear and flags expiry on the TIMEOUT-th enabled cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  wire logic i_clock,
  input  wire logic i_reset,
  input  wire logic i_clear,
  input  wire logic i_enable,
  output logic      o_expire
);
  localparam int             c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

  logic [c_CW-1:0] r_count;

  // Cycle counter: cleared by reset or an accepted byte, advances while enabled
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is only meaningful while the owner is actually waiting for a byte
  assign o_expire = i_enable && (r_count == c_LAST);
endmodule
`default_nettype wire

// File: rtl/alu_uart_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_uart_sequencer
//  Description : Collects a 3-byte frame (A, B, Op) from the UART, drives the
//                registered ALU, then returns result byte and status byte.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int N       = 8,
  parameter int NSel    = 6,
  parameter int TIMEOUT = 1_000_000
) (
  input  wire logic            i_clock,
  input  wire logic            i_reset,
  alu_uart_sequencer_if.master bus
);
  seq_state_t      r_state;
  seq_state_t      w_next_state;
  logic [N-1:0]    r_alu_A;
  logic [N-1:0]    r_alu_B;
  logic [NSel-1:0] r_alu_Op;
  logic [7:0]      r_tx_data;
  logic            r_ovf;
  logic            r_exec_last;
  logic            w_timer_clear;
  logic            w_timer_en;
  logic            w_expire;
  logic            w_timeout;

  // Timer only runs while waiting for the 2nd or 3rd byte of a frame
  assign w_timer_en = (r_state == S_GET_B) || (r_state == S_GET_OP);

  frame_timer #(.TIMEOUT(TIMEOUT)) u_frame_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic; an expiring timer takes priority over a byte arriving
  always_comb begin
    w_next_state  = r_state;
    w_timer_clear = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_rx_done) begin
          w_next_state  = S_GET_B;
          w_timer_clear = 1'b1;
        end
      end
      S_GET_B, S_GET_OP: begin
        if (w_expire) begin
          w_next_state  = S_IDLE;
          w_timer_clear = 1'b1;
          w_timeout     = 1'b1;
        end else if (bus.i_rx_done) begin
          w_next_state  = (r_state == S_GET_B) ? S_GET_OP : S_EXEC;
          w_timer_clear = 1'b1;
        end
      end
      S_EXEC:      if (r_exec_last)     w_next_state = S_SEND_RES;
      S_SEND_RES:                       w_next_state = S_WAIT_RES;
      S_WAIT_RES:  if (bus.i_tx_done)   w_next_state = S_SEND_STAT;
      S_SEND_STAT:                      w_next_state = S_WAIT_STAT;
      S_WAIT_STAT: if (bus.i_tx_done)   w_next_state = S_IDLE;
      default:                          w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, EXEC phase tracking and response byte staging
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_alu_A     <= '0;
      r_alu_B     <= '0;
      r_alu_Op    <= '0;
      r_tx_data   <= '0;
      r_ovf       <= 1'b0;
      r_exec_last <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.i_rx_done)
        r_alu_A <= bus.i_rx_data[N-1:0];
      if (r_state == S_GET_B && bus.i_rx_done && !w_expire)
        r_alu_B <= bus.i_rx_data[N-1:0];
      if (r_state == S_GET_OP && bus.i_rx_done && !w_expire)
        r_alu_Op <= bus.i_rx_data[NSel-1:0];

      // EXEC spans two cycles: one for the ALU to register, one to read it
      r_exec_last <= (r_state == S_EXEC) ? ~r_exec_last : 1'b0;

      if (r_state == S_EXEC && r_exec_last) begin
        r_tx_data <= 8'(bus.i_alu_result);
        r_ovf     <= bus.i_alu_overflow;
      end else if (r_state == S_WAIT_RES && bus.i_tx_done) begin
        r_tx_data <= {7'b0, r_ovf};
      end
    end
  end

  assign bus.o_alu_A    = r_alu_A;
  assign bus.o_alu_B    = r_alu_B;
  assign bus.o_alu_Op   = r_alu_Op;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_tx_start = (r_state == S_SEND_RES) || (r_state == S_SEND_STAT);
  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_timeout  = w_timeout;
endmodule
`default_nettype wire

// File: tb/tb_alu_uart_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_uart_sequencer
//  Description : Drives command frames through the sequencer with a
//                registered ALU model and a UART byte model; a monitor
//                scores every transmitted byte against a queue of expected
//                responses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_uart_sequencer;
  import alu_pkg::*;

  localparam int c_TO = 16;

  typedef struct {
    logic [7:0] data;
    bit         first;
    int         rxc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   start_cnt;
  int   to_cnt;
  int   to_cyc;
  int   tx_cnt;
  bit   outstanding;
  bit   prev_start;
  exp_t sb[$];

  alu_uart_sequencer_if #(.N(8), .NSel(6)) bus ();

  alu_uart_sequencer #(.N(8), .NSel(6), .TIMEOUT(c_TO)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Registered reference ALU with signed overflow on ADD/SUB
  always_ff @(posedge clk) begin
    logic [7:0] a, b, r;
    a = bus.o_alu_A;
    b = bus.o_alu_B;
    r = 8'h00;
    bus.i_alu_overflow <= 1'b0;
    case (bus.o_alu_Op)
      c_OP_ADD: begin r = a + b; bus.i_alu_overflow <= (a[7] == b[7]) && (r[7] != a[7]); end
      c_OP_SUB: begin r = a - b; bus.i_alu_overflow <= (a[7] != b[7]) && (r[7] != a[7]); end
      c_OP_AND: r = a & b;
      c_OP_OR:  r = a | b;
      c_OP_XOR: r = a ^ b;
      c_OP_SRA: r = 8'($signed(a) >>> b);
      c_OP_SRL: r = a >> b;
      c_OP_NOR: r = ~(a | b);
      default:  r = 8'h00;
    endcase
    bus.i_alu_result <= r;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART TX model: acknowledges each started byte five cycles later
  initial begin
    tx_cnt = 0;
    bus.i_tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_tx_done = 1'b0;
      if (rst) begin
        tx_cnt = 0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) bus.i_tx_done = 1'b1;
      end else if (bus.o_tx_start) begin
        tx_cnt = 5;
      end
    end
  end

  // Monitor: scores transmitted bytes, handshake ordering and timeout pulses
  initial begin
    exp_t e;
    start_cnt   = 0;
    to_cnt      = 0;
    to_cyc      = -1;
    outstanding = 0;
    prev_start  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        sb.delete();
        outstanding = 0;
        prev_start  = 0;
      end else begin
        if (bus.i_tx_done) outstanding = 0;
        if (bus.o_tx_start) begin
          start_cnt++;
          chk("start_not_back_to_back", {31'b0, prev_start}, 32'd0);
          chk("start_before_tx_done", {31'b0, outstanding}, 32'd0);
          outstanding = 1;
          if (sb.size() == 0) begin
            chk("unexpected_tx_start", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("tx_data", {24'b0, bus.o_tx_data}, {24'b0, e.data});
            if (e.first) chk("first_start_latency", cyc - e.rxc, 32'd3);
          end
        end
        prev_start = bus.o_tx_start;
        if (bus.o_timeout) begin
          to_cnt++;
          to_cyc = cyc;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int c);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] r0, input logic [7:0] r1);
    int c;
    exp_t e;
    send_byte(a, c);
    send_byte(b, c);
    send_byte(op, c);
    e.data = r0; e.first = 1; e.rxc = c; sb.push_back(e);
    e.data = r1; e.first = 0; e.rxc = 0; sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200 && (bus.o_busy || sb.size() != 0); i++) @(negedge clk);
    chk(name, {31'b0, bus.o_busy || (sb.size() != 0)}, 32'd0);
  endtask

  task automatic wait_start(input int s0);
    int i;
    for (i = 0; i < 50 && start_cnt == s0; i++) @(negedge clk);
    if (start_cnt == s0) chk("wait_first_start", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_A"},       {24'b0, bus.o_alu_A},   32'd0);
    chk({tag, "_B"},       {24'b0, bus.o_alu_B},   32'd0);
    chk({tag, "_Op"},      {26'b0, bus.o_alu_Op},  32'd0);
    chk({tag, "_tx_data"}, {24'b0, bus.o_tx_data}, 32'd0);
    chk({tag, "_start"},   {31'b0, bus.o_tx_start}, 32'd0);
    chk({tag, "_busy"},    {31'b0, bus.o_busy},    32'd0);
    chk({tag, "_timeout"}, {31'b0, bus.o_timeout}, 32'd0);
  endtask

  initial begin
    int c, s0;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    // ADD 5+3
    send_frame(8'h05, 8'h03, 8'h20, 8'h08, 8'h00);
    chk("add_A",  {24'b0, bus.o_alu_A},  32'h05);
    chk("add_B",  {24'b0, bus.o_alu_B},  32'h03);
    chk("add_Op", {26'b0, bus.o_alu_Op}, 32'h20);
    wait_idle("add_done");

    // ADD with signed overflow, then AND
    send_frame(8'h7F, 8'h01, 8'h20, 8'h80, 8'h01);
    wait_idle("ovf_done");
    send_frame(8'h0F, 8'h3C, 8'h24, 8'h0C, 8'h00);
    wait_idle("and_done");

    // Unknown opcode (upper rx bits ignored, 0x3F stays 0x3F)
    send_frame(8'hAA, 8'h55, 8'h3F, 8'h00, 8'h00);
    chk("unk_Op", {26'b0, bus.o_alu_Op}, 32'h3F);
    wait_idle("unk_done");

    // Timeout after a single byte
    s0 = to_cnt;
    send_byte(8'h11, c);
    repeat (20) @(negedge clk);
    chk("timeout_count", to_cnt - s0, 32'd1);
    chk("timeout_latency", to_cyc - c, c_TO);
    chk("timeout_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("timeout_A_kept", {24'b0, bus.o_alu_A}, 32'h11);
    send_frame(8'h02, 8'h02, 8'h22, 8'h00, 8'h00);
    wait_idle("sub_done");

    // Stray rx byte while waiting on TX
    s0 = start_cnt;
    send_frame(8'h09, 8'h01, 8'h20, 8'h0A, 8'h00);
    wait_start(s0);
    send_byte(8'hFF, c);
    chk("stray_A_kept", {24'b0, bus.o_alu_A}, 32'h09);
    wait_idle("stray_done");
    chk("stray_start_pulses", start_cnt - s0, 32'd2);

    // Reset while waiting for the opcode
    send_byte(8'h01, c);
    send_byte(8'h02, c);
    pulse_reset();
    chk_reset_outputs("rst_getop");

    // Reset while waiting for the result byte to finish
    s0 = start_cnt;
    send_frame(8'h04, 8'h04, 8'h20, 8'h08, 8'h01);
    wait_start(s0);
    pulse_reset();
    chk_reset_outputs("rst_waitres");
    repeat (12) @(negedge clk);
    chk("rst_no_more_start", start_cnt - s0, 32'd1);

    // Normal frame after resets: OR
    send_frame(8'h03, 8'h04, 8'h25, 8'h07, 8'h00);
    wait_idle("or_done");
    chk("frame_bytes_seen", c_FRAME_LEN + c_RESP_LEN, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
